// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: N-to-1 word select with a registered valid/ready output
// and a 2-entry skid buffer.
//
// Each accepted transfer carries its own select code. The select is resolved
// at accept time and the chosen word is registered. An out-of-range select
// either loads FILL as a normal transfer or is consumed silently
// (DROP_ILLEGAL=1). In both cases it pulses sel_err and bumps the saturating
// err_count.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data [NUM_IN*W]   packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel  [SEL_W]      select code for this transfer
//   in_valid / in_ready  upstream handshake (in_ready is a flop = skid empty)
//   out_data/out_valid   registered selected word
//   out_ready            downstream accepts
//   sel_err              one-cycle pulse after an illegal select is accepted
//   err_count [CNT_W]    saturating count of accepted illegal selects
//   clr_err              synchronous clear of err_count (wins over increment)
module mux_nto1_pipe #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      NUM_IN       = 3,
  parameter int unsigned      SEL_W        = 2,
  parameter logic [WIDTH-1:0] FILL         = '0,
  parameter bit               DROP_ILLEGAL = 1'b0,
  parameter int unsigned      CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        err_count,
  input  logic                    clr_err
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  logic [WIDTH-1:0] sel_word;
  logic             sel_legal;
  logic             accept;
  logic             emit;
  logic             store;
  logic             illegal_acc;

  logic [WIDTH-1:0] out_data_d;
  logic             out_valid_d;
  logic [WIDTH-1:0] skid_data_d;
  logic             skid_valid_d;

  // Compare against each legal code instead of indexing by in_sel, so an
  // out-of-range code can never address beyond the packed input vector.
  always_comb begin
    sel_word  = FILL;
    sel_legal = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_word  = in_data[k*WIDTH +: WIDTH];
        sel_legal = 1'b1;
      end
    end
  end

  assign accept      = in_valid && in_ready;
  assign emit        = out_valid && out_ready;
  assign store       = accept && (sel_legal || !DROP_ILLEGAL);
  assign illegal_acc = accept && !sel_legal;

  // in_ready mirrors "skid empty", so while the skid holds a word no
  // accept can happen and the only move is skid -> output on emit.
  always_comb begin
    out_data_d   = out_data;
    out_valid_d  = out_valid;
    skid_data_d  = skid_data;
    skid_valid_d = skid_valid;
    if (skid_valid) begin
      if (emit) begin
        out_data_d   = skid_data;
        skid_valid_d = 1'b0;
      end
    end else if (store) begin
      if (!out_valid || emit) begin
        out_data_d  = sel_word;
        out_valid_d = 1'b1;
      end else begin
        skid_data_d  = sel_word;
        skid_valid_d = 1'b1;
      end
    end else if (emit) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      sel_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      skid_data  <= skid_data_d;
      skid_valid <= skid_valid_d;
      in_ready   <= !skid_valid_d;
      sel_err    <= illegal_acc;
      if (clr_err) begin
        err_count <= '0;
      end else if (illegal_acc && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe. Two instances share all inputs:
//   u0: fill mode (DROP_ILLEGAL=0), 2-bit error counter
//   u1: drop mode (DROP_ILLEGAL=1), 8-bit error counter
// A directed vector table, a mid-transfer reset sequence and a random run
// against a FIFO-of-two reference model.
module tb_mux_nto1_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        out_ready;
  logic        clr_err;

  logic        ir0, ov0, se0;
  logic [31:0] od0;
  logic [1:0]  ec0;
  logic        ir1, ov1, se1;
  logic [31:0] od1;
  logic [7:0]  ec1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DROP_ILLEGAL(1'b0), .CNT_W(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
    .sel_err(se0), .err_count(ec0), .clr_err(clr_err));

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DROP_ILLEGAL(1'b1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
    .sel_err(se1), .err_count(ec1), .clr_err(clr_err));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic        ordy;
    logic        clr;
    logic        ir;
    logic        se;
    logic        ov0;
    logic [31:0] od0;
    logic [1:0]  ec0;
    logic        ov1;
    logic [31:0] od1;
    logic [7:0]  ec1;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [1:0] sel, logic ordy, logic clr, logic ir, logic se,
                              logic v0, logic [31:0] d0, logic [1:0] c0,
                              logic v1, logic [31:0] d1, logic [7:0] c1);
    vec_t r;
    r.iv = iv; r.sel = sel; r.ordy = ordy; r.clr = clr; r.ir = ir; r.se = se;
    r.ov0 = v0; r.od0 = d0; r.ec0 = c0; r.ov1 = v1; r.od1 = d1; r.ec1 = c1;
    return r;
  endfunction

  // Reference model: each instance is a FIFO of at most two words.
  logic [31:0] mq [2][2];
  int unsigned mcnt [2];
  int unsigned mec  [2];
  logic        mse  [2];

  task automatic model_step();
    logic        legal;
    logic [31:0] word;
    logic        acc;
    int unsigned cmax;
    legal = (in_sel < 2'd3);
    word  = legal ? in_data[int'(in_sel)*32 +: 32] : 32'h0;
    for (int d = 0; d < 2; d++) begin
      cmax = (d == 0) ? 3 : 255;
      acc  = in_valid && (mcnt[d] < 2);
      if (out_ready && mcnt[d] > 0) begin
        mq[d][0] = mq[d][1];
        mcnt[d]--;
      end
      if (acc && (legal || d == 0)) begin
        mq[d][mcnt[d]] = word;
        mcnt[d]++;
      end
      mse[d] = acc && !legal;
      if (clr_err) mec[d] = 0;
      else if (acc && !legal && mec[d] < cmax) mec[d]++;
    end
  endtask

  vec_t tbl [22];

  initial begin
    tbl[0]  = mk(1,0,1,0, 1,0, 1,32'h1,0,   1,32'h1,0);
    tbl[1]  = mk(1,1,1,0, 1,0, 1,32'h10,0,  1,32'h10,0);
    tbl[2]  = mk(1,2,1,0, 1,0, 1,32'h100,0, 1,32'h100,0);
    tbl[3]  = mk(0,0,1,0, 1,0, 0,32'h0,0,   0,32'h0,0);
    tbl[4]  = mk(1,3,1,0, 1,1, 1,32'h0,1,   0,32'h0,1);
    tbl[5]  = mk(0,0,1,0, 1,0, 0,32'h0,1,   0,32'h0,1);
    tbl[6]  = mk(1,0,0,0, 1,0, 1,32'h1,1,   1,32'h1,1);
    tbl[7]  = mk(1,1,0,0, 0,0, 1,32'h1,1,   1,32'h1,1);
    tbl[8]  = mk(1,2,0,0, 0,0, 1,32'h1,1,   1,32'h1,1);
    tbl[9]  = mk(1,2,1,0, 1,0, 1,32'h10,1,  1,32'h10,1);
    tbl[10] = mk(1,2,1,0, 1,0, 1,32'h100,1, 1,32'h100,1);
    tbl[11] = mk(0,0,1,0, 1,0, 0,32'h0,1,   0,32'h0,1);
    tbl[12] = mk(1,3,1,0, 1,1, 1,32'h0,2,   0,32'h0,2);
    tbl[13] = mk(1,3,1,0, 1,1, 1,32'h0,3,   0,32'h0,3);
    tbl[14] = mk(1,3,1,0, 1,1, 1,32'h0,3,   0,32'h0,4);
    tbl[15] = mk(1,3,1,0, 1,1, 1,32'h0,3,   0,32'h0,5);
    tbl[16] = mk(1,3,1,1, 1,1, 1,32'h0,0,   0,32'h0,0);
    tbl[17] = mk(0,0,1,0, 1,0, 0,32'h0,0,   0,32'h0,0);
    tbl[18] = mk(1,0,1,0, 1,0, 1,32'h1,0,   1,32'h1,0);
    tbl[19] = mk(1,3,1,0, 1,1, 1,32'h0,1,   0,32'h0,1);
    tbl[20] = mk(1,1,1,0, 1,0, 1,32'h10,1,  1,32'h10,1);
    tbl[21] = mk(0,0,1,0, 1,0, 0,32'h0,1,   0,32'h0,1);

    rst_n     = 1'b0;
    in_data   = {32'h100, 32'h10, 32'h1};
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;

    #12;
    chk("rst_ov0", 32'(ov0), 32'h0);  chk("rst_od0", od0, 32'h0);
    chk("rst_ir0", 32'(ir0), 32'h1);  chk("rst_se0", 32'(se0), 32'h0);
    chk("rst_ec0", 32'(ec0), 32'h0);  chk("rst_ov1", 32'(ov1), 32'h0);
    chk("rst_ir1", 32'(ir1), 32'h1);  chk("rst_ec1", 32'(ec1), 32'h0);
    rst_n = 1'b1;

    // Directed vectors: outputs checked 1 time unit after each edge.
    for (int i = 0; i < 22; i++) begin
      in_valid  = tbl[i].iv;
      in_sel    = tbl[i].sel;
      out_ready = tbl[i].ordy;
      clr_err   = tbl[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ir0", i), 32'(ir0), 32'(tbl[i].ir));
      chk($sformatf("v%0d_ir1", i), 32'(ir1), 32'(tbl[i].ir));
      chk($sformatf("v%0d_se0", i), 32'(se0), 32'(tbl[i].se));
      chk($sformatf("v%0d_se1", i), 32'(se1), 32'(tbl[i].se));
      chk($sformatf("v%0d_ov0", i), 32'(ov0), 32'(tbl[i].ov0));
      chk($sformatf("v%0d_ov1", i), 32'(ov1), 32'(tbl[i].ov1));
      chk($sformatf("v%0d_ec0", i), 32'(ec0), 32'(tbl[i].ec0));
      chk($sformatf("v%0d_ec1", i), 32'(ec1), 32'(tbl[i].ec1));
      if (tbl[i].ov0) chk($sformatf("v%0d_od0", i), od0, tbl[i].od0);
      if (tbl[i].ov1) chk($sformatf("v%0d_od1", i), od1, tbl[i].od1);
    end

    // Fill both stages with two words, then reset asynchronously mid-cycle.
    out_ready = 1'b0; clr_err = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0;
    @(posedge clk); #1;
    in_sel = 2'd1;
    @(posedge clk); #1;
    chk("full_ir0", 32'(ir0), 32'h0);
    chk("full_ir1", 32'(ir1), 32'h0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov0", 32'(ov0), 32'h0); chk("arst_ir0", 32'(ir0), 32'h1);
    chk("arst_od0", od0, 32'h0);      chk("arst_ec0", 32'(ec0), 32'h0);
    chk("arst_ov1", 32'(ov1), 32'h0); chk("arst_ir1", 32'(ir1), 32'h1);
    chk("arst_ec1", 32'(ec1), 32'h0);
    #2;
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 2'd2; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ov0", 32'(ov0), 32'h1); chk("post_rst_od0", od0, 32'h100);
    chk("post_rst_ov1", 32'(ov1), 32'h1); chk("post_rst_od1", od1, 32'h100);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_ov0", 32'(ov0), 32'h0);
    chk("drain_ov1", 32'(ov1), 32'h0);

    // Random traffic against the model (both stages empty, counters at 0).
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0; mec[d] = 0; mse[d] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      in_data   = {$urandom, $urandom, $urandom};
      in_sel    = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_err   = ($urandom_range(0, 15) == 0);
      model_step();
      @(posedge clk); #1;
      chk("rnd_ov0", 32'(ov0), 32'(mcnt[0] > 0));
      chk("rnd_ir0", 32'(ir0), 32'(mcnt[0] < 2));
      chk("rnd_se0", 32'(se0), 32'(mse[0]));
      chk("rnd_ec0", 32'(ec0), mec[0]);
      if (mcnt[0] > 0) chk("rnd_od0", od0, mq[0][0]);
      chk("rnd_ov1", 32'(ov1), 32'(mcnt[1] > 0));
      chk("rnd_ir1", 32'(ir1), 32'(mcnt[1] < 2));
      chk("rnd_se1", 32'(se1), 32'(mse[1]));
      chk("rnd_ec1", 32'(ec1), mec[1]);
      if (mcnt[1] > 0) chk("rnd_od1", od1, mq[1][0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
- Parametrised N-to-1 datapath select stage, successor to the fixed 3:1 combinational select muxes in the datapath (ALU-source, write-back and forwarding selects).
- Each transfer carries its own select code; the selected word is registered with a valid/ready handshake and a 2-entry skid buffer, so the stage can sit between pipeline registers without breaking the stall path.
- An out-of-range select is detected, counted and either forwarded as a defined fill word or dropped. An out-of-range select never produces X.

Parameters:
- WIDTH, 32, bits per input word and output word.
- NUM_IN, 3, number of inputs; legal range 2..2**SEL_W.
- SEL_W, 2, width of the select code.
- FILL, 32'h0000_0000, output word for an illegal select when DROP_ILLEGAL=0.
- DROP_ILLEGAL, 0, 1 = consume an illegal-select transfer without emitting it; 0 = emit FILL.
- CNT_W, 8, width of the illegal-select counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  select code for this transfer.
- in_valid  in  1  input transfer offered.
- in_ready  out  1  stage can accept a transfer.
- out_data  out  WIDTH  selected word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- sel_err  out  1  one-cycle pulse, registered; set on the cycle after an illegal select is accepted.
- err_count  out  CNT_W  count of accepted illegal selects; saturates at all-ones.
- clr_err  in  1  synchronous clear of err_count.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, in_ready=1, sel_err=0, err_count=0, skid buffer empty.
- Accept: a transfer is accepted when in_valid && in_ready. Emit: a transfer is emitted when out_valid && out_ready.
- in_ready is a pure register output equal to "skid empty". There is no combinational path from out_ready to in_ready.
- Latency: an accepted transfer appears on out_data/out_valid on the next clock edge when the output register is empty or emitting that cycle.
- Throughput: sustained 1 transfer/cycle while out_ready=1.
- Select: in_sel < NUM_IN selects in_data[in_sel*WIDTH +: WIDTH]. in_sel >= NUM_IN is illegal.
- The select decision is made at accept time. The registered word is not re-muxed later.
- Illegal select, DROP_ILLEGAL=0: FILL is loaded as a normal transfer.
- Illegal select, DROP_ILLEGAL=1: the transfer is consumed; nothing is stored and out_valid is unaffected.
- Illegal select, either mode: sel_err pulses and err_count increments on the edge after accept.
- Skid buffer: if a legal transfer is accepted while the output register is full and not emitting, the word goes to the skid register and in_ready drops next cycle.
- On the next emit, the skid word moves to the output register and in_ready rises on the following cycle.
- Ordering is strictly FIFO. Max occupancy is 2 words.
- A full stage (2 words held) never accepts a transfer and never drops data.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Simultaneous accept and emit with one word held: the output register takes the new word; the skid stays empty.
- err_count: clr_err has priority over an increment in the same cycle, so the result is 0. Holds at 2**CNT_W-1.
- Reset mid-transfer: all held words are discarded and outputs return to their reset values immediately (asynchronous).
- in_data and in_sel are don't-care when in_valid=0. X on them with in_valid=0 must not propagate to the outputs.

Test Plan:
- Basic select: NUM_IN=3; inputs 0x1, 0x10, 0x100; in_sel 0,1,2 on consecutive cycles, out_ready=1 -> out_data 0x1, 0x10, 0x100 on cycles 1,2,3; out_valid high for 3 cycles.
- Illegal select, fill mode: DROP_ILLEGAL=0, in_sel=3 -> out_data=0x00000000 with out_valid=1; sel_err pulses once; err_count=1; never X.
- Illegal select, drop mode: DROP_ILLEGAL=1; stream sel 0,3,1 -> only 0x1 then 0x10 emitted; err_count=1.
- Backpressure: out_ready=0 while streaming sel 0,1,2 -> two words held, in_ready=0 from the following cycle. Release out_ready -> 0x1, 0x10 emitted in order, then 0x100 accepted and emitted. No loss or duplication.
- Counter: CNT_W=2; 5 illegal selects -> err_count saturates at 3. Assert clr_err together with a sixth illegal select -> err_count=0.
- Reset: assert rst_n=0 while 2 words are held -> out_valid=0 and in_ready=1 immediately (asynchronous). After release, the first new transfer sees 1-cycle latency.
